// File: rtl/clk_div_prog_50.sv
// ---------------------------------------------------------------------------
// clk_div_prog_50
// Runtime-programmable integer clock divider with 50% duty cycle for both
// even and odd ratios. A new ratio is captured into a shadow register by a
// one-cycle load strobe and applied only at an output-period boundary, so
// every output phase belongs to exactly one ratio.
//
// Ports
//   i_clk        source clock (negedge used only for the odd-ratio stretch)
//   i_rst_n      asynchronous active-low reset
//   i_en         run enable (level); a stop completes the current period
//   i_div        requested ratio N (0 and 1 are clamped to 2)
//   i_div_load   one-cycle strobe capturing i_div into the shadow register
//   o_pending    shadow ratio captured but not yet applied
//   o_upd_done   one-cycle pulse in the cycle the new ratio takes effect
//   o_tick       one-cycle pulse in the count-0 cycle of each running period
//   o_clk        divided clock (flop, or AND of two flops for odd N)
// ---------------------------------------------------------------------------
module clk_div_prog_50 #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_DIV = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_div,
  input  logic             i_div_load,
  output logic             o_pending,
  output logic             o_upd_done,
  output logic             o_tick,
  output logic             o_clk
);

  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic {
    ST_STOP,
    ST_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shd_q, shd_d;
  logic             pend_q, pend_d;
  logic             upd_q, upd_d;
  logic             tick_q, tick_d;
  logic             pos_q, pos_d;
  logic             neg_q;

  logic [CNT_W-1:0] div_clamped;
  logic [CNT_W-1:0] half_d;
  logic             boundary;
  logic             running_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    shd_d       = shd_q;
    pend_d      = pend_q;
    upd_d       = 1'b0;
    boundary    = 1'b0;
    div_clamped = (i_div < TWO) ? TWO : i_div;

    case (state_q)
      ST_RUN: begin
        if (cnt_q == div_q - ONE) begin
          boundary = 1'b1;
          cnt_d    = '0;
          if (!i_en) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        cnt_d = '0;
        if (i_en) begin
          state_d  = ST_RUN;
          boundary = 1'b1;
        end
      end
    endcase

    // The stop edge and the restart edge are both period boundaries, so a
    // pending ratio is applied there too.
    if (boundary && pend_q) begin
      div_d  = shd_q;
      pend_d = 1'b0;
      upd_d  = 1'b1;
    end

    // Evaluated after the apply step: a strobe on the boundary edge applies
    // the old shadow and leaves the freshly captured value pending.
    if (i_div_load) begin
      shd_d  = div_clamped;
      pend_d = 1'b1;
    end

    running_d = (state_d == ST_RUN);
    tick_d    = running_d && boundary;
    half_d    = div_d >> 1;
    // Odd N keeps the posedge phase high one extra count (0..H); the negedge
    // copy ANDed in trims that back to H+0.5 cycles.
    pos_d     = running_d && (div_d[0] ? (cnt_d <= half_d) : (cnt_d < half_d));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_STOP;
      cnt_q   <= '0;
      div_q   <= DEF;
      shd_q   <= DEF;
      pend_q  <= 1'b0;
      upd_q   <= 1'b0;
      tick_q  <= 1'b0;
      pos_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      upd_q   <= upd_d;
      tick_q  <= tick_d;
      pos_q   <= pos_d;
    end
  end

  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) neg_q <= 1'b0;
    else          neg_q <= pos_q;
  end

  // div_q only changes at a boundary edge, where pos_q rises from 0 and
  // neg_q is already 0, so switching the select cannot glitch o_clk.
  assign o_clk      = div_q[0] ? (pos_q & neg_q) : pos_q;
  assign o_pending  = pend_q;
  assign o_upd_done = upd_q;
  assign o_tick     = tick_q;

endmodule

// File: doc/clk_div_prog_50.md
Name: clk_div_prog_50

Overview:
- Runtime-programmable integer clock divider producing a 50% duty-cycle output for both even and odd ratios.
- Generalises the fixed divide-by-7 divider:
  - CNT_W-bit ratio loaded through a handshake.
  - Ratio changes are glitch-free, applied only at output-period boundaries.
  - Clean enable/stop.
  - Per-period tick for same-domain logic.
- Sits in the clock-generation area and feeds peripheral clocks (UART/SPI baud, sampling clocks).

Parameters:
- CNT_W, 8, width of the ratio and of the internal counter; legal ratio range 2..2^CNT_W-1.
- DEF_DIV, 7, active ratio after reset; must be within the legal range.

Ports:
- i_clk  input  1  source clock; both edges used (negedge only for odd-ratio half-cycle stretch).
- i_rst_n  input  1  asynchronous active-low reset.
- i_en  input  1  run enable, level.
- i_div  input  CNT_W  requested ratio N.
- i_div_load  input  1  one-cycle strobe; captures i_div into the shadow register.
- o_pending  output  1  shadow ratio captured, not yet applied.
- o_upd_done  output  1  one-cycle pulse, asserted in the cycle the new ratio takes effect.
- o_tick  output  1  one-cycle pulse in the first i_clk cycle of each output period.
- o_clk  output  1  divided clock.

Behaviour:
- Reset (async, i_rst_n low):
  - Counter = 0; active ratio = DEF_DIV; shadow = DEF_DIV.
  - o_pending = 0, o_upd_done = 0, o_tick = 0, o_clk = 0.
  - Both posedge and negedge phase flops = 0.
  - Deassertion takes effect at the next posedge; no output edge until then.
- Counter: posedge, counts 0..N-1, then wraps to 0. One output period = N i_clk cycles.
- Output shape, with H = N>>1:
  - Even N: o_clk high for H cycles, low for H cycles. The rise coincides with the posedge that enters count 0.
  - Odd N: posedge phase flop high for counts 0..H (H+1 cycles). Negedge flop copies it half a cycle later. o_clk = posedge flop AND negedge flop, giving high for H+0.5 cycles and low for H+0.5 cycles.
  - Even N: o_clk = posedge flop; negedge flop ignored.
  - o_clk is always driven by a flop or a two-flop AND, never by logic on i_clk itself. No combinational path from any input to o_clk.
- Clamping: i_div values 0 and 1 are clamped to 2 at capture. No bypass mode.
- Ratio update handshake:
  - i_div_load high at a posedge: shadow <= clamp(i_div); o_pending <= 1.
  - A load while pending overwrites the shadow; only the last value is applied.
  - At the wrap posedge (counter = N-1 -> 0) with o_pending = 1: active ratio <= shadow, o_pending <= 0, o_upd_done pulses for one cycle. The new period starts with the new ratio.
  - A load strobe coinciding with the wrap edge:
    - The existing shadow is applied.
    - The new value is captured.
    - o_pending stays 1.
  - No period is ever truncated or stretched. Every o_clk high/low phase belongs to exactly one ratio.
- Enable:
  - i_en deasserted mid-period: the current period completes. At the wrap the counter holds at 0 and o_clk stays 0.
  - While stopped: o_tick = 0. Pending updates are still applied at the stop boundary.
  - i_en reasserted while stopped: the next posedge starts a period at count 0, with o_clk rising at that edge.
  - Reset asserted mid-period: o_clk goes 0 immediately. The pending shadow is lost.
- o_tick: high exactly during the count-0 cycle of each running period.

Test Plan:
- Reset, i_en=1, DEF_DIV=7 -> o_clk period 7 i_clk cycles, high 3.5 / low 3.5 cycles; o_tick every 7 cycles; no glitch narrower than 0.5 cycle.
- Load i_div=4 at mid-period of ratio 7 -> o_pending=1 until the next wrap, then o_upd_done pulses once; following periods are 4 cycles, 2 high / 2 low; the period containing the load is exactly 7.
- Load 5 then 9 before the boundary -> only 9 applied at the wrap; one o_upd_done pulse; period 9, high 4.5 cycles.
- Load i_div=0 and i_div=1 -> active ratio 2; o_clk = i_clk/2, 1 high / 1 low.
- Deassert i_en at count 2 of ratio 6 -> 4 further cycles complete the period, then o_clk=0, o_tick=0 held; reassert -> o_clk rises at the next posedge.
- Assert i_rst_n low mid-high phase with o_pending=1 -> o_clk=0 immediately; after release the ratio is DEF_DIV and o_pending=0.
